// File: rtl/shift_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// shift_arbiter_pkg
// Shared constants and types for the shift_arbiter block.
//   SHIFT_W : operand / result width of the shared shifter
//   AMT_W   : shift-amount width
//   state_e : arbiter FSM states (IDLE, EXEC, RESP)
// ----------------------------------------------------------------------------
package shift_arbiter_pkg;

    localparam int SHIFT_W = 8;
    localparam int AMT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/barrelshifterR.sv
// ----------------------------------------------------------------------------
// barrelshifterR
// Combinational 8-bit logical right barrel shifter, zero fill.
//   data_i : operand
//   amt_i  : shift amount (0..7)
//   data_o : data_i >> amt_i
// ----------------------------------------------------------------------------
module barrelshifterR (
    input  logic [7:0] data_i,
    input  logic [2:0] amt_i,
    output logic [7:0] data_o
);

    logic [7:0] stage1;
    logic [7:0] stage2;

    // Log shifter: stages of 1, 2 and 4 bit positions.
    assign stage1 = amt_i[0] ? {1'b0, data_i[7:1]} : data_i;
    assign stage2 = amt_i[1] ? {2'b0, stage1[7:2]} : stage1;
    assign data_o = amt_i[2] ? {4'b0, stage2[7:4]} : stage2;

endmodule

// File: rtl/shift_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The winner is the first requester with
// req_i set, searching last_grant_i+1, +2, ... modulo NREQ.
//   req_i        : request vector
//   last_grant_i : index of the previous winner
//   en_i         : when low, no grant is produced
//   grant_o      : one-hot grant (all zero if none)
//   grant_idx_o  : binary index of the winner (0 if none)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o
);

    always_comb begin
        int   cand;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_i) + k) % NREQ;
            if (en_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDW'(cand);
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// ----------------------------------------------------------------------------
// shift_arbiter
// Shares one barrelshifterR between NREQ requesters with round-robin
// arbitration and returns each result on a single response channel tagged
// with the requester index.
//
// Handshake: a transfer happens on a channel in a cycle where valid && ready.
// Requesters must not derive valid from ready, and must hold data/amt stable
// while valid is high and ready low. The response holds rsp_data/rsp_id
// stable while rsp_valid is high until rsp_ready.
//
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_ready  : per-requester request handshake (ready one-hot)
//   req_data, req_amt    : packed per-requester operand and shift amount
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data, rsp_id     : shifted result and issuing requester index
//   busy                 : high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*SHIFT_W-1:0] req_data,
    input  logic [NREQ*AMT_W-1:0]   req_amt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SHIFT_W-1:0]      rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    state_e               state_q;
    logic [SHIFT_W-1:0]   op_data_q;
    logic [AMT_W-1:0]     op_amt_q;
    logic [IDW-1:0]       op_id_q;
    logic [IDW-1:0]       last_grant_q;
    logic                 rsp_valid_q;
    logic [SHIFT_W-1:0]   rsp_data_q;
    logic [IDW-1:0]       rsp_id_q;

    logic                 window;
    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       grant_idx;
    logic                 accept;
    logic [SHIFT_W-1:0]   sel_data;
    logic [AMT_W-1:0]     sel_amt;
    logic [SHIFT_W-1:0]   shift_out;

    // Accept in IDLE, or in RESP in the cycle the current result drains.
    // rst_n gates the window so no ready is offered while in reset.
    assign window = rst_n &&
                    ((state_q == IDLE) ||
                     (state_q == RESP && rsp_valid_q && rsp_ready));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .en_i         (window),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign accept   = |grant;
    assign sel_data = req_data[int'(grant_idx)*SHIFT_W +: SHIFT_W];
    assign sel_amt  = req_amt[int'(grant_idx)*AMT_W +: AMT_W];

    barrelshifterR u_shifter (
        .data_i (op_data_q),
        .amt_i  (op_amt_q),
        .data_o (shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_data_q    <= '0;
            op_amt_q     <= '0;
            op_id_q      <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_data_q    <= sel_data;
                        op_amt_q     <= sel_amt;
                        op_id_q      <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= shift_out;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (accept) begin
                            op_data_q    <= sel_data;
                            op_amt_q     <= sel_amt;
                            op_id_q      <= grant_idx;
                            last_grant_q <= grant_idx;
                            state_q      <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule
